// File: rtl/axi_ni_response_header_packetizer_pkg.sv
// Shared NoC/NI constants for the response header packetizer: field widths,
// header offsets, flit-type and FSM encodings, and header packing helpers.
package axi_ni_response_header_packetizer_pkg;

  localparam int FTYPEWD               = 2;
  localparam int ROUTEWD               = 8;
  localparam int SOURCEWD              = 8;
  localparam int PACKETRESPTYPEWD      = 3;
  localparam int PACKETTRANSIDWD       = 8;
  localparam int COUNTERFLITWD         = 4;
  localparam int RH_RESP_BASE_TYPE     = 0;
  localparam int RH_RESP_BASE_TRANS_ID = 4;
  localparam int RESP_HEADERLENGTH     = 40;

  typedef enum logic [FTYPEWD-1:0] {
    FT_HEAD     = 2'd0,
    FT_BODY     = 2'd1,
    FT_TAIL     = 2'd2,
    FT_HEADTAIL = 2'd3
  } ftype_e;

  typedef enum logic [PACKETRESPTYPEWD-1:0] {
    RT_READ    = 3'd0,
    RT_EXREAD  = 3'd1,
    RT_WRITE   = 3'd2,
    RT_EXWRITE = 3'd3
  } resp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  function automatic int resp_headerflits(input int base_width);
    return (RESP_HEADERLENGTH + base_width - 1) / base_width;
  endfunction

  // Unknown encodings fall through to "not a read" so they carry no payload.
  function automatic logic type_is_read(input logic [PACKETRESPTYPEWD-1:0] rtype);
    return (rtype == RT_READ) || (rtype == RT_EXREAD);
  endfunction

  function automatic logic [RESP_HEADERLENGTH-1:0] pack_header(
    input logic [ROUTEWD-1:0]          route,
    input logic [SOURCEWD-1:0]         source,
    input logic [PACKETRESPTYPEWD-1:0] rtype,
    input logic [PACKETTRANSIDWD-1:0]  id
  );
    logic [RESP_HEADERLENGTH-1:0] hdr;
    hdr = '0;
    hdr[ROUTEWD-1:0]                                              = route;
    hdr[ROUTEWD +: SOURCEWD]                                      = source;
    hdr[RH_RESP_BASE_TYPE + SOURCEWD + ROUTEWD +: PACKETRESPTYPEWD] = rtype;
    hdr[RH_RESP_BASE_TRANS_ID + SOURCEWD + ROUTEWD +: PACKETTRANSIDWD] = id;
    return hdr;
  endfunction

endpackage

// File: rtl/axi_ni_response_header_packetizer_if.sv
// Request, payload and NoC flit channels of the response header packetizer.
interface axi_ni_response_header_packetizer_if
  import axi_ni_response_header_packetizer_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int BASE_WIDTH = FLIT_WIDTH - FTYPEWD
);

  logic                        hdr_valid;
  logic                        hdr_ready;
  logic [ROUTEWD-1:0]          hdr_route;
  logic [SOURCEWD-1:0]         hdr_source;
  logic [PACKETRESPTYPEWD-1:0] hdr_type;
  logic [PACKETTRANSIDWD-1:0]  hdr_id;
  logic                        pl_valid;
  logic [BASE_WIDTH-1:0]       pl_data;
  logic                        pl_last;
  logic                        pl_ready;
  logic [FLIT_WIDTH-1:0]       flit;
  logic                        flit_valid;
  logic                        flit_ready;

  modport slave (
    input  hdr_valid, hdr_route, hdr_source, hdr_type, hdr_id,
    input  pl_valid, pl_data, pl_last, flit_ready,
    output hdr_ready, pl_ready, flit, flit_valid
  );

  modport master (
    output hdr_valid, hdr_route, hdr_source, hdr_type, hdr_id,
    output pl_valid, pl_data, pl_last, flit_ready,
    input  hdr_ready, pl_ready, flit, flit_valid
  );

endinterface

// File: rtl/axi_ni_response_header_packetizer.sv
// Target-side NI: packs an AXI response header, serializes it as NoC flits and
// then passes read payload beats straight through to the NoC port.
module axi_ni_response_header_packetizer
  import axi_ni_response_header_packetizer_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int BASE_WIDTH = FLIT_WIDTH - FTYPEWD
) (
  input  logic clk_i,
  input  logic rst_ni,
  axi_ni_response_header_packetizer_if.slave bus,
  output logic busy_o
);

  localparam int HDR_FLITS = resp_headerflits(BASE_WIDTH);
  localparam int HDR_PAD_W = HDR_FLITS * BASE_WIDTH;
  localparam logic [COUNTERFLITWD-1:0] LAST_CNT = COUNTERFLITWD'(HDR_FLITS - 1);

  state_e                       state_q, state_d;
  logic [RESP_HEADERLENGTH-1:0] header_q, header_d;
  logic [COUNTERFLITWD-1:0]     cnt_q, cnt_d;
  logic                         is_read_q, is_read_d;

  logic [HDR_PAD_W-1:0]         header_pad_s;
  logic [BASE_WIDTH-1:0]        hdr_slice_s;
  logic                         last_hdr_s;
  ftype_e                       hdr_ftype_s;
  ftype_e                       pl_ftype_s;

  // Zero padding fills the tail of the last header flit.
  assign header_pad_s = HDR_PAD_W'(header_q);
  assign last_hdr_s   = (cnt_q == LAST_CNT);
  assign busy_o       = (state_q != ST_IDLE);

  // Select the header slice addressed by the flit counter.
  always_comb begin
    hdr_slice_s = '0;
    for (int i = 0; i < HDR_FLITS; i++) begin
      hdr_slice_s = hdr_slice_s
                  | ({BASE_WIDTH{cnt_q == COUNTERFLITWD'(i)}}
                     & header_pad_s[i*BASE_WIDTH +: BASE_WIDTH]);
    end
  end

  // Flit types for header flits and pass-through payload beats.
  always_comb begin
    hdr_ftype_s = FT_BODY;
    if (cnt_q == '0) begin
      hdr_ftype_s = (last_hdr_s && !is_read_q) ? FT_HEADTAIL : FT_HEAD;
    end else if (last_hdr_s && !is_read_q) begin
      hdr_ftype_s = FT_TAIL;
    end else begin
      hdr_ftype_s = FT_BODY;
    end
    pl_ftype_s = bus.pl_last ? FT_TAIL : FT_BODY;
  end

  // Packet FSM: next state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    header_d       = header_q;
    cnt_d          = cnt_q;
    is_read_d      = is_read_q;
    bus.hdr_ready  = 1'b0;
    bus.pl_ready   = 1'b0;
    bus.flit_valid = 1'b0;
    bus.flit       = '0;
    case (state_q)
      ST_IDLE: begin
        bus.hdr_ready = 1'b1;
        if (bus.hdr_valid) begin
          header_d  = pack_header(bus.hdr_route, bus.hdr_source, bus.hdr_type, bus.hdr_id);
          is_read_d = type_is_read(bus.hdr_type);
          cnt_d     = '0;
          state_d   = ST_HEADER;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_HEADER: begin
        bus.flit_valid = 1'b1;
        bus.flit       = {hdr_slice_s, hdr_ftype_s};
        if (bus.flit_ready) begin
          if (last_hdr_s) begin
            cnt_d   = '0;
            state_d = is_read_q ? ST_PAYLOAD : ST_IDLE;
          end else begin
            cnt_d   = cnt_q + COUNTERFLITWD'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PAYLOAD: begin
        bus.flit_valid = bus.pl_valid;
        bus.pl_ready   = bus.flit_ready;
        bus.flit       = {bus.pl_data, pl_ftype_s};
        if (bus.pl_valid && bus.flit_ready && bus.pl_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched header and flit counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      header_q  <= '0;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      header_q  <= header_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
    end
  end

endmodule

// File: tb/tb_axi_ni_response_header_packetizer.sv
// Randomized scoreboard bench for the response header packetizer with a
// built-in receiver-side header decoder.
module tb_axi_ni_response_header_packetizer;
  import axi_ni_response_header_packetizer_pkg::*;

  localparam int FW  = 32;
  localparam int BW  = FW - FTYPEWD;
  localparam int HF  = (RESP_HEADERLENGTH + BW - 1) / BW;
  localparam int FW1 = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy1;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   tail_cyc = -1;
  int   hs_cyc = -1;
  int   rdy_mode = 0;
  int   rdy_phase = 0;

  logic [63:0] exp_q[$];
  int          kind_q[$];
  logic [127:0] rx_hdr = '0;
  logic [7:0]   rx_source = '0;
  logic [7:0]   rx_id = '0;
  logic [2:0]   rx_type = '0;
  bit           stall_prev = 1'b0;
  logic [31:0]  stall_flit = '0;

  axi_ni_response_header_packetizer_if #(.FLIT_WIDTH(FW))  bus  ();
  axi_ni_response_header_packetizer_if #(.FLIT_WIDTH(FW1)) bus1 ();

  axi_ni_response_header_packetizer #(.FLIT_WIDTH(FW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave), .busy_o(busy)
  );

  axi_ni_response_header_packetizer #(.FLIT_WIDTH(FW1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_header(input logic [7:0] route, input logic [7:0] src,
                                               input logic [2:0] typ, input logic [7:0] id);
    return 64'(route)
         | (64'(src) << ROUTEWD)
         | (64'(typ) << (ROUTEWD + SOURCEWD + RH_RESP_BASE_TYPE))
         | (64'(id)  << (ROUTEWD + SOURCEWD + RH_RESP_BASE_TRANS_ID));
  endfunction

  // NoC-side readiness: always, random, or the 1-0-0-1 stall pattern
  initial begin
    bus.flit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.flit_ready = 1'b1;
        1: bus.flit_ready = ($urandom_range(0, 2) != 0);
        default: begin
          bus.flit_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
          rdy_phase++;
        end
      endcase
    end
  end

  // Monitor: scoreboard pop, hold-stability, payload gating and header decode
  initial begin
    logic [63:0] e;
    int k;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (stall_prev && bus.flit_valid)
          check("hold_stable", bus.flit, stall_flit);
        if (bus.pl_valid && exp_q.size() > 0)
          check("pl_ready_gate", bus.pl_ready, (kind_q[0] < 0) ? bus.flit_ready : 1'b0);
        if (bus.flit_valid && bus.flit_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_flit: got 0x%0h, expected no flit", bus.flit);
          end else begin
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            check("flit", bus.flit, e);
            if (e[1:0] == FT_TAIL || e[1:0] == FT_HEADTAIL) tail_cyc = cyc;
            if (k >= 0) begin
              rx_hdr[k*BW +: BW] = bus.flit[FW-1:FTYPEWD];
              if (k == HF - 1) begin
                rx_source = rx_hdr[ROUTEWD +: SOURCEWD];
                rx_type   = rx_hdr[ROUTEWD + SOURCEWD + RH_RESP_BASE_TYPE +: PACKETRESPTYPEWD];
                rx_id     = rx_hdr[ROUTEWD + SOURCEWD + RH_RESP_BASE_TRANS_ID +: PACKETTRANSIDWD];
              end
            end
          end
        end
        stall_prev = bus.flit_valid && !bus.flit_ready;
        stall_flit = bus.flit;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [29:0] data, input bit last);
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
    end
    bus.pl_valid = 1'b1;
    bus.pl_data  = data;
    bus.pl_last  = last;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.pl_ready) begin
        @(posedge clk);
        #1;
        bus.pl_valid = 1'b0;
        bus.pl_last  = 1'b0;
        return;
      end
    end
    check("beat_timeout", 64'd1, 64'd0);
    bus.pl_valid = 1'b0;
  endtask

  // Pushes the whole expected packet, then drives header and ndrive beats
  task automatic send_packet(input logic [7:0] route, input logic [7:0] src, input logic [2:0] typ,
                             input logic [7:0] id, input int nbeats, input int ndrive,
                             input logic [29:0] base, input bit rnd);
    logic [63:0] h;
    logic [63:0] w;
    logic [29:0] pl [8];
    logic [1:0]  ft;
    int n, total;
    bit ok;
    n = (typ == 3'd0 || typ == 3'd1) ? nbeats : 0;
    total = HF + n;
    h = model_header(route, src, typ, id);
    for (int i = 0; i < n; i++) pl[i] = rnd ? 30'($urandom) : base + 30'(i);
    for (int p = 0; p < total; p++) begin
      if (p < HF) w = (h >> (p * BW)) & ((64'd1 << BW) - 64'd1);
      else        w = 64'(pl[p - HF]);
      if (p == 0)              ft = (total == 1) ? FT_HEADTAIL : FT_HEAD;
      else if (p == total - 1) ft = FT_TAIL;
      else                     ft = FT_BODY;
      exp_q.push_back(64'({w[BW-1:0], ft}));
      kind_q.push_back((p < HF) ? p : -1);
    end
    bus.hdr_valid  = 1'b1;
    bus.hdr_route  = route;
    bus.hdr_source = src;
    bus.hdr_type   = typ;
    bus.hdr_id     = id;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (bus.hdr_ready) begin
        hs_cyc = cyc;
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    if (!ok) check("hdr_timeout", 64'd1, 64'd0);
    for (int i = 0; i < n && i < ndrive; i++) send_beat(pl[i], i == n - 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("idle_timeout", 64'd1, 64'd0);
    exp_q.delete();
    kind_q.delete();
  endtask

  task automatic check_rx(input string tag, input logic [7:0] id, input bit rd, input bit lk);
    check({tag, "_id"}, rx_id, id);
    check({tag, "_read"}, (rx_type == RT_READ || rx_type == RT_EXREAD), rd);
    check({tag, "_locked"}, (rx_type == RT_EXREAD || rx_type == RT_EXWRITE), lk);
  endtask

  initial begin
    int cnt1;
    logic [63:0] f1, h1;
    bus.hdr_valid = 1'b0; bus.hdr_route = '0; bus.hdr_source = '0; bus.hdr_type = '0; bus.hdr_id = '0;
    bus.pl_valid = 1'b0; bus.pl_data = '0; bus.pl_last = 1'b0;
    bus1.hdr_valid = 1'b0; bus1.hdr_route = '0; bus1.hdr_source = '0; bus1.hdr_type = '0;
    bus1.hdr_id = '0; bus1.pl_valid = 1'b0; bus1.pl_data = '0; bus1.pl_last = 1'b0;
    bus1.flit_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hdr_ready", bus.hdr_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_flit_valid", bus.flit_valid, 1'b0);
    check("rst_pl_ready", bus.pl_ready, 1'b0);
    check("rst_flit", bus.flit, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    rdy_mode = 0;
    send_packet(8'h03, 8'h05, RT_WRITE, 8'h2A, 0, 0, 30'h0, 1'b0);
    wait_idle();
    check("wr_source", rx_source, 8'h05);
    check_rx("wr", 8'h2A, 1'b0, 1'b0);

    send_packet(8'h07, 8'h05, RT_EXREAD, 8'h11, 4, 4, 30'hA0, 1'b0);
    wait_idle();
    check_rx("exrd", 8'h11, 1'b1, 1'b1);

    rdy_mode = 2;
    send_packet(8'h44, 8'h09, RT_READ, 8'h5C, 4, 4, 30'h1234, 1'b1);
    wait_idle();
    check_rx("stall", 8'h5C, 1'b1, 1'b0);

    rdy_mode = 0;
    send_packet(8'h01, 8'h02, RT_WRITE, 8'h10, 0, 0, 30'h0, 1'b0);
    send_packet(8'h03, 8'h04, RT_EXWRITE, 8'h20, 0, 0, 30'h0, 1'b0);
    check("b2b_gap", 64'(hs_cyc - tail_cyc), 64'd1);
    wait_idle();

    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      int nb;
      nb = $urandom_range(1, 4);
      send_packet(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
                  nb, nb, 30'h0, 1'b1);
    end
    wait_idle();

    rdy_mode = 0;
    send_packet(8'h0F, 8'h06, RT_EXREAD, 8'h77, 4, 2, 30'hB0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flit_valid", bus.flit_valid, 1'b0);
    check("mid_rst_hdr_ready", bus.hdr_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pl_ready", bus.pl_ready, 1'b0);
    exp_q.delete();
    kind_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_packet(8'h0E, 8'h06, RT_EXWRITE, 8'h33, 0, 0, 30'h0, 1'b0);
    wait_idle();
    check_rx("post_rst", 8'h33, 1'b0, 1'b1);

    h1 = model_header(8'h12, 8'h34, RT_WRITE, 8'h56);
    bus1.hdr_valid = 1'b1; bus1.hdr_route = 8'h12; bus1.hdr_source = 8'h34;
    bus1.hdr_type = RT_WRITE; bus1.hdr_id = 8'h56;
    @(negedge clk);
    check("w64_hdr_ready", bus1.hdr_ready, 1'b1);
    @(posedge clk);
    #1;
    bus1.hdr_valid = 1'b0;
    cnt1 = 0;
    f1 = '0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus1.flit_valid && bus1.flit_ready) begin
        cnt1++;
        if (cnt1 == 1) f1 = bus1.flit;
      end
    end
    check("w64_flit_count", 64'(cnt1), 64'd1);
    check("w64_headtail", f1, {h1[61:0], FT_HEADTAIL});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_ni_response_header_packetizer.md
# axi_ni_response_header_packetizer

Target-side NI block that builds an AXI response packet header and serializes it onto the NoC, followed by optional payload flits. It mirrors the initiator-side `axi_ni_response_header_register`: each header bit it packs is decoded back to the same field by that receiver. It sits between the target NI response FSM and the NoC output port.

## Interface
- `FLIT_WIDTH`, default 32: NoC flit width.
- `BASE_WIDTH`, default `FLIT_WIDTH - `FTYPEWD`: header/payload bits carried per flit.
- Constants `RESP_HEADERLENGTH`, `RESP_HEADERFLITS`, `RH_RESP_BASE_TYPE`, `RH_RESP_BASE_TRANS_ID` come from `ni_parameters.v`. Widths and encodings come from `noc_parameters.v`.
- Reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  block clock.
- `rst`  in  1  asynchronous active-low reset.
- `hdr_valid`  in  1  new response request.
- `hdr_ready`  out  1  request accepted when high together with `hdr_valid`.
- `hdr_route`  in  `ROUTEWD`  route to the initiator.
- `hdr_source`  in  `SOURCEWD`  this target's source id.
- `hdr_type`  in  `PACKETRESPTYPEWD`  READ / EXREAD / WRITE / EXWRITE.
- `hdr_id`  in  `PACKETTRANSIDWD`  transaction id.
- `pl_valid`  in  1  payload beat valid.
- `pl_data`  in  `BASE_WIDTH`  payload beat.
- `pl_last`  in  1  final payload beat.
- `pl_ready`  out  1  payload beat consumed.
- `flit`  out  `FLIT_WIDTH`  outgoing flit; type field in `[FTYPEWD-1:0]`.
- `flit_valid`  out  1  flit valid.
- `flit_ready`  in  1  NoC accepts flit.
- `busy`  out  1  packet in progress (state != IDLE).

## Operation
- FSM states:
  - IDLE: `hdr_ready`=1. On `hdr_valid`, latch all fields into `header[RESP_HEADERLENGTH-1:0]`, clear `cnt`, go to HEADER.
  - HEADER: `flit_valid`=1 and `flit[FTYPEWD+k] = header[BASE_WIDTH*cnt + k]`. Each `flit_valid && flit_ready` increments `cnt`. On the last header flit (`cnt == RESP_HEADERFLITS-1`):
    - READ or EXREAD: go to PAYLOAD.
    - WRITE or EXWRITE: go to IDLE.
  - PAYLOAD: pass-through, with `flit_valid = pl_valid`, `pl_ready = flit_ready`, `flit = {pl_data, ftype}`. An accepted beat with `pl_last` set goes to IDLE.
- Header packing, exact inverse of the receiver:
  - `header[ROUTEWD-1:0]` = route.
  - `header[SOURCEWD+ROUTEWD-1:ROUTEWD]` = source.
  - The type field sits at offset `RH_RESP_BASE_TYPE+SOURCEWD+ROUTEWD`.
  - The id field sits at offset `RH_RESP_BASE_TRANS_ID+SOURCEWD+ROUTEWD`.
  - All other bits are 0.
  - Bits beyond `RESP_HEADERLENGTH` in the last header flit are 0.
- Flit type rules:
  - The first flit is HEAD, or HEADTAIL if it is also the packet's last flit.
  - The last header flit of a write response is TAIL.
  - The `pl_last` beat is TAIL.
  - All other flits are BODY.
- `cnt` is `COUNTERFLITWD` wide and never exceeds `RESP_HEADERFLITS-1`.
- Unknown `hdr_type` encodings are treated as write, so the packet carries no payload.

## Timing
- Reset values:
  - State IDLE, so `hdr_ready`=1 and `busy`=0.
  - `flit_valid`=0, `pl_ready`=0, `flit`=0.
  - `header`=0, `cnt`=0.
- Latency: the first header flit is valid the cycle after the `hdr_valid`/`hdr_ready` handshake.
- Header flits need `RESP_HEADERFLITS` cycles at full `flit_ready`. Payload beats add no latency because they are combinational pass-through.
- Once `flit_valid` is high in HEADER, `flit` is held stable until accepted.
- `flit_ready` low stalls without loss.
- A new header is never accepted in the cycle the previous packet ends: `hdr_ready` rises the cycle after. Back-to-back packets therefore have one idle cycle between them.
- `pl_ready`=0 outside PAYLOAD. Payload presented early is held off.
- Reset asserted mid-packet returns to IDLE immediately. The packet is truncated and no TAIL is emitted.

## Structure
- Flit-type encodings (HEAD/BODY/TAIL/HEADTAIL) and the FSM state encoding go in `noc_parameters.v`, next to `FTYPEWD`. Header offsets stay in `ni_parameters.v`.
- Single module, no sub-modules. The header-slice mux is a `for` loop over `RESP_HEADERFLITS`.

## Test plan
The bench runs in loopback into `axi_ni_response_header_register`, sampling each header flit.
- Write, route=0x3, source=0x5, id=0x2A, type=WRITE:
  - Flits are HEAD…TAIL, header flits only.
  - Receiver reports `message_source`=0x5, `received_id`=0x2A, `packet_type_is_read`=0, `message_is_locked`=0.
- EXREAD with id=0x11 and 4 beats 0xA0..0xA3:
  - Header flits, then 3 BODY flits and 1 TAIL carrying 0xA3.
  - Receiver reports read=1, locked=1.
- `flit_ready` toggling 1-0-0-1 during the header: each flit is held stable and none is duplicated or dropped. The same check runs in PAYLOAD with `pl_valid` gaps.
- Two requests queued back-to-back: the second `hdr_ready` rises exactly one cycle after the first packet's TAIL handshake.
- Reset pulsed in PAYLOAD after beat 2:
  - `flit_valid`=0, `hdr_ready`=1, `busy`=0 immediately.
  - The next EXWRITE packet is correct: locked=1, read=0.
- Build with `RESP_HEADERFLITS`=1 and a WRITE request: exactly one flit is emitted, typed HEADTAIL.
